nco_seq: RTL and testbench
==========================

// Module: nco_seq
// PURPOSE
//   Command sequencer for one per-qubit NCO. Buffers gate commands in a small FIFO and drives
//   the NCO config/enable strobes (ftw_wr_en/ftw_out, z_corr_wr_en/z_corr_out, phase_wr_en).
//   Virtual-Z rotations accumulate in an internal phase register. Sits between the gate
//   scheduler and the NCO.
// PARAMETERS
//   N            22  frequency tuning word width
//   Z_CORR_WIDTH 12  z-correction (virtual-Z phase) width
//   DUR_WIDTH     8  PLAY/WAIT duration field width, in cycles
//   FIFO_DEPTH    4  command FIFO entries; power of 2, >=2
// PORTS
//   clk           in   1             clock; all logic on rising edge
//   rst           in   1             synchronous active-low reset (0 = reset)
//   flush         in   1             abort: clear FIFO and current op
//   cmd_valid     in   1             command valid
//   cmd_ready     out  1             command accepted when cmd_valid & cmd_ready
//   cmd_op        in   2             00 SET_FTW, 01 VZ, 10 PLAY, 11 WAIT
//   cmd_data      in   N             FTW (SET_FTW) / phase increment in [Z_CORR_WIDTH-1:0] (VZ)
//   cmd_dur       in   DUR_WIDTH     cycles for PLAY/WAIT; 0 is treated as 1
//   ftw_wr_en     out  1             one-cycle FTW write strobe to NCO
//   ftw_out       out  N             FTW value, valid with ftw_wr_en
//   z_corr_wr_en  out  1             one-cycle z-correction write strobe to NCO
//   z_corr_out    out  Z_CORR_WIDTH  accumulated virtual-Z phase
//   phase_wr_en   out  1             NCO phase-advance enable
//   busy          out  1             FIFO non-empty or an op in progress
// BEHAVIOUR
// - Reset (rst==0 at edge): FIFO empty, FSM IDLE, zacc=0, all outputs 0, except cmd_ready=1
//   on the first cycle after reset is released. Reset mid-op aborts immediately.
// - cmd_ready = !fifo_full & !flush. A push when full is impossible. A pop in the same cycle
//   does not raise cmd_ready.
// - FSM states: IDLE, FTW, ZC, PLAY, WAIT. Dispatch pops the FIFO head when state==IDLE, or
//   when the current op is in its last cycle, and the FIFO is non-empty (back-to-back, no
//   bubble). With an empty FIFO after the last cycle, the FSM returns to IDLE.
// - Latency: a command accepted at edge t into an empty FIFO with FSM IDLE is dispatched at
//   edge t+1. Its outputs are registered and visible in the cycle after edge t+1.
// - SET_FTW: 1 cycle; ftw_wr_en=1, ftw_out=cmd_data. ftw_out holds its value afterwards.
// - VZ: 1 cycle; zacc <= zacc + cmd_data[Z_CORR_WIDTH-1:0], mod 2^Z_CORR_WIDTH (wraps, no
//   carry out). z_corr_wr_en=1 and z_corr_out = new zacc.
// - PLAY: phase_wr_en=1 for max(cmd_dur,1) consecutive cycles. WAIT: phase_wr_en=0 for
//   max(cmd_dur,1) cycles. The down-counter loads dur-1; the last cycle is count==0.
// - Strobes ftw_wr_en and z_corr_wr_en are high exactly 1 cycle per op, never simultaneously.
// - flush=1 at edge: FIFO cleared, FSM->IDLE, phase_wr_en/strobes 0 next cycle. zacc and
//   ftw_out are retained. flush beats a simultaneous push (command dropped, not acknowledged).
// - busy = (state!=IDLE) | !fifo_empty.
// CONFIGURATION
// - NCO_SEQ_STATS_EN defined: adds output play_cnt[15:0], counting cycles with phase_wr_en=1.
//   It saturates at 16'hFFFF and is cleared by reset only (not by flush).
// - Not defined: no play_cnt port or counter. All other behaviour is identical.
// TESTING
// 1. Reset low 2 cycles, release -> all outputs 0, cmd_ready=1, busy=0.
// 2. Push SET_FTW data=22'h000800 into idle -> ftw_wr_en=1 one cycle, 2nd cycle after
//    acceptance, ftw_out=22'h000800.
// 3. Push VZ 12'h800, then VZ 12'h900 -> z_corr_out=12'h800, then 12'h100 (wrap) on adjacent
//    cycles, with 2 z_corr_wr_en pulses.
// 4. Push PLAY dur=100, WAIT dur=10, PLAY dur=100 back-to-back -> phase_wr_en high 100, low 10,
//    high 100 cycles, no gap. PLAY dur=0 -> high exactly 1.
// 5. Fill FIFO (4 WAIT dur=50) while busy -> cmd_ready=0 until first pop; 5th push stalls.
// 6. flush during PLAY dur=200 with 2 queued -> phase_wr_en=0 next cycle, busy=0, zacc kept.
//    With NCO_SEQ_STATS_EN, play_cnt equals the high cycles counted.

Source files
------------

// File: rtl/nco_seq.sv
// nco_seq: command FIFO plus sequencer that drives the NCO FTW / virtual-Z / phase-advance strobes.
// Defining NCO_SEQ_STATS_EN adds the play_cnt output (saturating count of phase-advance cycles).
module nco_seq #(
   parameter int N            = 22,
   parameter int Z_CORR_WIDTH = 12,
   parameter int DUR_WIDTH    = 8,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [1:0]              cmd_op,
   input  logic [N-1:0]            cmd_data,
   input  logic [DUR_WIDTH-1:0]    cmd_dur,
   output logic                    ftw_wr_en,
   output logic [N-1:0]            ftw_out,
   output logic                    z_corr_wr_en,
   output logic [Z_CORR_WIDTH-1:0] z_corr_out,
   output logic                    phase_wr_en,
   output logic                    busy
`ifdef NCO_SEQ_STATS_EN
   ,
   output logic [15:0]             play_cnt
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_FTW  = 3'd1,
      ST_ZC   = 3'd2,
      ST_PLAY = 3'd3,
      ST_WAIT = 3'd4
   } state_t;

   logic [1:0]              op_mem_r   [FIFO_DEPTH];
   logic [N-1:0]            data_mem_r [FIFO_DEPTH];
   logic [DUR_WIDTH-1:0]    dur_mem_r  [FIFO_DEPTH];
   logic [AW-1:0]           rd_ptr_r;
   logic [AW-1:0]           wr_ptr_r;
   logic [AW:0]             count_r;

   state_t                  state_r;
   logic [DUR_WIDTH-1:0]    cnt_r;
   logic                    ftw_wr_en_r;
   logic [N-1:0]            ftw_out_r;
   logic                    z_corr_wr_en_r;
   logic [Z_CORR_WIDTH-1:0] zacc_r;
   logic                    phase_wr_en_r;

   logic                    fifo_full_s;
   logic                    fifo_empty_s;
   logic                    push_s;
   logic                    pop_s;
   logic                    last_s;
   logic [1:0]              head_op_s;
   logic [N-1:0]            head_data_s;
   logic [DUR_WIDTH-1:0]    head_dur_s;
   logic [DUR_WIDTH-1:0]    dur_m1_s;

   assign fifo_full_s  = (count_r == DEPTH_C);
   assign fifo_empty_s = (count_r == (AW+1)'(0));
   assign cmd_ready    = !fifo_full_s && !flush;
   assign push_s       = cmd_valid && cmd_ready;
   assign pop_s        = last_s && !fifo_empty_s && !flush;

   assign head_op_s    = op_mem_r[rd_ptr_r];
   assign head_data_s  = data_mem_r[rd_ptr_r];
   assign head_dur_s   = dur_mem_r[rd_ptr_r];
   // A zero duration behaves as one cycle, so the counter never underflows.
   assign dur_m1_s     = (head_dur_s == {DUR_WIDTH{1'b0}}) ? {DUR_WIDTH{1'b0}}
                                                           : head_dur_s - DUR_WIDTH'(1);

   // Current op is in its final cycle (or no op is running), so the next head may dispatch.
   always_comb begin
      last_s = 1'b1;
      case (state_r)
         ST_IDLE, ST_FTW, ST_ZC: last_s = 1'b1;
         ST_PLAY, ST_WAIT:       last_s = (cnt_r == {DUR_WIDTH{1'b0}});
         default:                last_s = 1'b1;
      endcase
   end

   // Command storage; contents are don't-care until the pointers say otherwise.
   always_ff @(posedge clk) begin
      if (push_s) begin
         op_mem_r[wr_ptr_r]   <= cmd_op;
         data_mem_r[wr_ptr_r] <= cmd_data;
         dur_mem_r[wr_ptr_r]  <= cmd_dur;
      end
   end

   // FIFO pointers and occupancy; flush empties the queue and wins over push/pop.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr_r <= AW'(0);
         wr_ptr_r <= AW'(0);
         count_r  <= (AW+1)'(0);
      end else if (flush) begin
         rd_ptr_r <= AW'(0);
         wr_ptr_r <= AW'(0);
         count_r  <= (AW+1)'(0);
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         count_r <= count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
      end
   end

   // Sequencer FSM with registered NCO strobes; zacc and ftw_out survive a flush.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r        <= ST_IDLE;
         cnt_r          <= {DUR_WIDTH{1'b0}};
         ftw_wr_en_r    <= 1'b0;
         ftw_out_r      <= {N{1'b0}};
         z_corr_wr_en_r <= 1'b0;
         zacc_r         <= {Z_CORR_WIDTH{1'b0}};
         phase_wr_en_r  <= 1'b0;
      end else if (flush) begin
         state_r        <= ST_IDLE;
         cnt_r          <= {DUR_WIDTH{1'b0}};
         ftw_wr_en_r    <= 1'b0;
         z_corr_wr_en_r <= 1'b0;
         phase_wr_en_r  <= 1'b0;
      end else begin
         ftw_wr_en_r    <= 1'b0;
         z_corr_wr_en_r <= 1'b0;
         if (pop_s) begin
            case (head_op_s)
               2'b00: begin
                  state_r       <= ST_FTW;
                  ftw_wr_en_r   <= 1'b1;
                  ftw_out_r     <= head_data_s;
                  phase_wr_en_r <= 1'b0;
               end
               2'b01: begin
                  state_r        <= ST_ZC;
                  zacc_r         <= zacc_r + head_data_s[Z_CORR_WIDTH-1:0];
                  z_corr_wr_en_r <= 1'b1;
                  phase_wr_en_r  <= 1'b0;
               end
               2'b10: begin
                  state_r       <= ST_PLAY;
                  cnt_r         <= dur_m1_s;
                  phase_wr_en_r <= 1'b1;
               end
               default: begin
                  state_r       <= ST_WAIT;
                  cnt_r         <= dur_m1_s;
                  phase_wr_en_r <= 1'b0;
               end
            endcase
         end else if (last_s) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {DUR_WIDTH{1'b0}};
            phase_wr_en_r <= 1'b0;
         end else begin
            cnt_r <= cnt_r - DUR_WIDTH'(1);
         end
      end
   end

   assign ftw_wr_en    = ftw_wr_en_r;
   assign ftw_out      = ftw_out_r;
   assign z_corr_wr_en = z_corr_wr_en_r;
   assign z_corr_out   = zacc_r;
   assign phase_wr_en  = phase_wr_en_r;
   assign busy         = (state_r != ST_IDLE) || !fifo_empty_s;

`ifdef NCO_SEQ_STATS_EN
   logic [15:0] play_cnt_r;

   // Saturating count of phase-advance cycles; only reset clears it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         play_cnt_r <= 16'd0;
      end else if (phase_wr_en_r && (play_cnt_r != 16'hFFFF)) begin
         play_cnt_r <= play_cnt_r + 16'd1;
      end else begin
         play_cnt_r <= play_cnt_r;
      end
   end

   assign play_cnt = play_cnt_r;
`endif

endmodule

// File: tb/tb_nco_seq.sv
// Self-checking bench for nco_seq: directed scenarios plus random traffic against a
// schedule-level model (each command gets a dispatch edge and a duration window).
module tb_nco_seq;
   localparam int N  = 22;
   localparam int ZW = 12;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [N-1:0]  cmd_data;
   logic [DW-1:0] cmd_dur;
   logic          ftw_wr_en;
   logic [N-1:0]  ftw_out;
   logic          z_corr_wr_en;
   logic [ZW-1:0] z_corr_out;
   logic          phase_wr_en;
   logic          busy;
`ifdef NCO_SEQ_STATS_EN
   logic [15:0]   play_cnt;
`endif

   nco_seq dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_data     (cmd_data),
      .cmd_dur      (cmd_dur),
      .ftw_wr_en    (ftw_wr_en),
      .ftw_out      (ftw_out),
      .z_corr_wr_en (z_corr_wr_en),
      .z_corr_out   (z_corr_out),
      .phase_wr_en  (phase_wr_en),
      .busy         (busy)
`ifdef NCO_SEQ_STATS_EN
      ,
      .play_cnt     (play_cnt)
`endif
   );

   always #5 clk = ~clk;

   // One accepted command: acceptance edge a, dispatch edge d, active after edges d..d+len-1.
   typedef struct {
      logic [1:0]   op;
      logic [N-1:0] data;
      int           a;
      int           d;
      int           len;
   } op_t;

   op_t ops[$];
   int  e = 0;
   int  errors = 0;
   int  checks = 0;
   int  play_hist = 0;

   int  obs_phase_hi = 0;
   int  obs_ftw_pulses = 0;
   int  last_ftw_edge = -1;
   logic prev_ph = 1'b0;
   int  rise_edges[$];
   logic [ZW-1:0] z_vals[$];
   int  z_edges[$];

   function automatic int occ_at(input int t);
      int n = 0;
      foreach (ops[i]) if (ops[i].a <= t && ops[i].d > t) n++;
      return n;
   endfunction

   function automatic logic op_active(input int t, input logic [1:0] o);
      foreach (ops[i]) if (ops[i].op == o && ops[i].d <= t && t < ops[i].d + ops[i].len) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic any_active(input int t);
      foreach (ops[i]) if (ops[i].d <= t && t < ops[i].d + ops[i].len) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic strobe_at(input int t, input logic [1:0] o);
      foreach (ops[i]) if (ops[i].op == o && ops[i].d == t) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [N-1:0] ftw_at(input int t);
      logic [N-1:0] v = {N{1'b0}};
      foreach (ops[i]) if (ops[i].op == 2'b00 && ops[i].d <= t) v = ops[i].data;
      return v;
   endfunction

   function automatic logic [ZW-1:0] z_at(input int t);
      logic [ZW-1:0] v = {ZW{1'b0}};
      foreach (ops[i]) if (ops[i].op == 2'b01 && ops[i].d <= t) v = v + ops[i].data[ZW-1:0];
      return v;
   endfunction

   function automatic logic busy_at(input int t);
      return (occ_at(t) > 0) || any_active(t);
   endfunction

   function automatic int end_max();
      int m = 0;
      foreach (ops[i]) if (ops[i].d + ops[i].len > m) m = ops[i].d + ops[i].len;
      return m;
   endfunction

   task automatic apply_flush(input int f);
      op_t kept[$];
      op_t o;
      foreach (ops[i]) begin
         o = ops[i];
         if (o.d < f) begin
            if (o.d + o.len > f) o.len = f - o.d;
            kept.push_back(o);
         end
      end
      ops = kept;
   endtask

   task automatic check_outputs();
      logic          x_ftw_en, x_z_en, x_ph, x_busy;
      logic [N-1:0]  x_ftw;
      logic [ZW-1:0] x_z;
      x_ftw_en = strobe_at(e, 2'b00);
      x_z_en   = strobe_at(e, 2'b01);
      x_ph     = op_active(e, 2'b10);
      x_busy   = busy_at(e);
      x_ftw    = ftw_at(e);
      x_z      = z_at(e);
      checks++; if (ftw_wr_en !== x_ftw_en) begin errors++; $display("FAIL ftw_wr_en edge=%0d got=%b exp=%b", e, ftw_wr_en, x_ftw_en); end
      checks++; if (ftw_out !== x_ftw) begin errors++; $display("FAIL ftw_out edge=%0d got=%h exp=%h", e, ftw_out, x_ftw); end
      checks++; if (z_corr_wr_en !== x_z_en) begin errors++; $display("FAIL z_corr_wr_en edge=%0d got=%b exp=%b", e, z_corr_wr_en, x_z_en); end
      checks++; if (z_corr_out !== x_z) begin errors++; $display("FAIL z_corr_out edge=%0d got=%h exp=%h", e, z_corr_out, x_z); end
      checks++; if (phase_wr_en !== x_ph) begin errors++; $display("FAIL phase_wr_en edge=%0d got=%b exp=%b", e, phase_wr_en, x_ph); end
      checks++; if (busy !== x_busy) begin errors++; $display("FAIL busy edge=%0d got=%b exp=%b", e, busy, x_busy); end
`ifdef NCO_SEQ_STATS_EN
      checks++; if (play_cnt !== 16'(play_hist)) begin errors++; $display("FAIL play_cnt edge=%0d got=%0d exp=%0d", e, play_cnt, play_hist); end
      if (x_ph) play_hist++;
`endif
      if (phase_wr_en === 1'b1) obs_phase_hi++;
      if (phase_wr_en === 1'b1 && prev_ph !== 1'b1) rise_edges.push_back(e);
      prev_ph = phase_wr_en;
      if (ftw_wr_en === 1'b1) begin obs_ftw_pulses++; last_ftw_edge = e; end
      if (z_corr_wr_en === 1'b1) begin z_vals.push_back(z_corr_out); z_edges.push_back(e); end
   endtask

   task automatic clear_obs();
      obs_phase_hi = 0;
      obs_ftw_pulses = 0;
      last_ftw_edge = -1;
      rise_edges.delete();
      z_vals.delete();
      z_edges.delete();
   endtask

   // One clock: drive inputs, check cmd_ready, advance the model at the edge, check outputs.
   task automatic drive(input logic v, input logic [1:0] op, input logic [N-1:0] data,
                        input logic [DW-1:0] dur, input logic fl, output logic acc);
      logic exp_rdy;
      op_t  n;
      int   m;
      cmd_valid = v;
      cmd_op    = op;
      cmd_data  = data;
      cmd_dur   = dur;
      flush     = fl;
      #1;
      exp_rdy = (occ_at(e) < 4) && !fl;
      checks++;
      if (cmd_ready !== exp_rdy) begin
         errors++;
         $display("FAIL cmd_ready edge=%0d got=%b exp=%b", e, cmd_ready, exp_rdy);
      end
      acc = v && exp_rdy;
      @(posedge clk);
      e++;
      if (fl) begin
         apply_flush(e);
      end else if (acc) begin
         m      = end_max();
         n.op   = op;
         n.data = data;
         n.a    = e;
         n.d    = (m > e + 1) ? m : e + 1;
         n.len  = op[1] ? ((dur == 8'd0) ? 1 : int'(dur)) : 1;
         ops.push_back(n);
      end
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) drive(1'b0, 2'b00, {N{1'b0}}, 8'd0, 1'b0, acc);
   endtask

   task automatic push_wait(input logic [1:0] op, input logic [N-1:0] data,
                            input logic [DW-1:0] dur, output int acc_edge);
      logic acc = 1'b0;
      int   k = 0;
      while (!acc && k < 400) begin
         drive(1'b1, op, data, dur, 1'b0, acc);
         k++;
      end
      acc_edge = e;
      checks++;
      if (!acc) begin errors++; $display("FAIL push_timeout edge=%0d got=stalled exp=accepted", e); end
      cmd_valid = 1'b0;
   endtask

   task automatic drain(input int bound);
      int k = 0;
      while (busy_at(e) && k < bound) begin idle(1); k++; end
      checks++;
      if (busy_at(e)) begin errors++; $display("FAIL drain_timeout edge=%0d got=busy exp=idle", e); end
      idle(2);
   endtask

   task automatic test_reset();
      logic acc;
      rst = 1'b0; flush = 1'b0; cmd_valid = 1'b0;
      cmd_op = 2'b00; cmd_data = {N{1'b0}}; cmd_dur = 8'd0;
      repeat (2) begin
         @(posedge clk); e++;
         ops.delete(); play_hist = 0;
         #1; check_outputs();
      end
      rst = 1'b1;
      drive(1'b0, 2'b00, {N{1'b0}}, 8'd0, 1'b0, acc);
      idle(2);
   endtask

   task automatic test_set_ftw();
      int a;
      clear_obs();
      push_wait(2'b00, 22'h000800, 8'd0, a);
      drain(20);
      checks++; if (obs_ftw_pulses !== 1) begin errors++; $display("FAIL ftw_pulses got=%0d exp=1", obs_ftw_pulses); end
      checks++; if (last_ftw_edge - a !== 1) begin errors++; $display("FAIL ftw_latency got=%0d exp=1", last_ftw_edge - a); end
      checks++; if (ftw_out !== 22'h000800) begin errors++; $display("FAIL ftw_hold got=%h exp=000800", ftw_out); end
   endtask

   task automatic test_vz_wrap();
      int a;
      clear_obs();
      push_wait(2'b01, 22'h000800, 8'd0, a);
      push_wait(2'b01, 22'h000900, 8'd0, a);
      drain(20);
      checks++;
      if (z_vals.size() !== 2) begin
         errors++; $display("FAIL vz_pulses got=%0d exp=2", z_vals.size());
      end else begin
         checks++; if (z_vals[0] !== 12'h800) begin errors++; $display("FAIL vz_first got=%h exp=800", z_vals[0]); end
         checks++; if (z_vals[1] !== 12'h100) begin errors++; $display("FAIL vz_wrap got=%h exp=100", z_vals[1]); end
         checks++; if (z_edges[1] - z_edges[0] !== 1) begin errors++; $display("FAIL vz_adjacent got=%0d exp=1", z_edges[1] - z_edges[0]); end
      end
   endtask

   task automatic test_back_to_back();
      int a;
      clear_obs();
      push_wait(2'b10, {N{1'b0}}, 8'd100, a);
      push_wait(2'b11, {N{1'b0}}, 8'd10, a);
      push_wait(2'b10, {N{1'b0}}, 8'd100, a);
      drain(400);
      checks++; if (obs_phase_hi !== 200) begin errors++; $display("FAIL b2b_high got=%0d exp=200", obs_phase_hi); end
      checks++;
      if (rise_edges.size() !== 2) begin
         errors++; $display("FAIL b2b_rises got=%0d exp=2", rise_edges.size());
      end else begin
         checks++; if (rise_edges[1] - rise_edges[0] !== 110) begin errors++; $display("FAIL b2b_spacing got=%0d exp=110", rise_edges[1] - rise_edges[0]); end
      end
      clear_obs();
      push_wait(2'b10, {N{1'b0}}, 8'd0, a);
      drain(20);
      checks++; if (obs_phase_hi !== 1) begin errors++; $display("FAIL play_dur0 got=%0d exp=1", obs_phase_hi); end
   endtask

   task automatic test_fill();
      int a0, a, a4, a5;
      push_wait(2'b10, {N{1'b0}}, 8'd20, a0);
      for (int i = 0; i < 4; i++) push_wait(2'b11, {N{1'b0}}, 8'd50, a4);
      push_wait(2'b11, {N{1'b0}}, 8'd50, a5);
      checks++; if (a4 - a0 !== 4) begin errors++; $display("FAIL fill_accept got=%0d exp=4", a4 - a0); end
      checks++; if (a5 - a0 !== 22) begin errors++; $display("FAIL fill_stall got=%0d exp=22", a5 - a0); end
      a = a5;
      drain(400);
   endtask

   task automatic test_flush();
      int   a;
      logic acc;
      push_wait(2'b10, {N{1'b0}}, 8'd200, a);
      push_wait(2'b11, {N{1'b0}}, 8'd5, a);
      push_wait(2'b01, 22'h000123, 8'd0, a);
      idle(40);
      drive(1'b1, 2'b01, 22'h000055, 8'd0, 1'b1, acc);
      checks++; if (phase_wr_en !== 1'b0) begin errors++; $display("FAIL flush_phase got=%b exp=0", phase_wr_en); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
      checks++; if (z_corr_out !== 12'h100) begin errors++; $display("FAIL flush_zacc got=%h exp=100", z_corr_out); end
      checks++; if (ftw_out !== 22'h000800) begin errors++; $display("FAIL flush_ftw got=%h exp=000800", ftw_out); end
      idle(3);
   endtask

   task automatic test_random();
      logic [31:0] r;
      logic        acc;
      for (int i = 0; i < 1500; i++) begin
         r = $urandom;
         drive(r[0], r[2:1], 22'($urandom), {5'd0, r[7:5]}, (r[13:8] == 6'd0), acc);
      end
      drain(200);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog edge=%0d got=running exp=finished", e);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_set_ftw();
      test_vz_wrap();
      test_back_to_back();
      test_fill();
      test_flush();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
